// File: rtl/pll_seq_pkg.sv
// Shared types and default timing for the PLL reset sequencer.
// State encoding is visible on state_dbg, so values are fixed.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_PLLRST   = 3'd0,
    S_WAITLOCK = 3'd1,
    S_STABLE   = 3'd2,
    S_RELEASE  = 3'd3,
    S_RUN      = 3'd4
  } state_t;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_LOSS_FILTER   = 4;
  localparam int DEF_NUM_DOMAINS   = 4;
  localparam int DEF_RELEASE_GAP   = 8;
  localparam int DEF_RETRY_W       = 4;

  function automatic int max4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Synchronous clear forces both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  // capture the async input, then re-time it once more
  always_ff @(posedge clk) begin
    if (clr) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and lock supervision on the reference clock.
// Pulses PLL reset, qualifies lock, then staggers domain releases.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int LOSS_FILTER   = DEF_LOSS_FILTER,
  parameter int NUM_DOMAINS   = DEF_NUM_DOMAINS,
  parameter int RELEASE_GAP   = DEF_RELEASE_GAP,
  parameter int RETRY_W       = DEF_RETRY_W
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] dom_reset,
  output logic                   ready,
  output logic [RETRY_W-1:0]     retry_cnt,
  output logic                   lock_lost,
  output logic [2:0]             state_dbg
);

  localparam int TMAX = max4(
    RST_CYCLES,
    LOCK_TIMEOUT,
    STABLE_CYCLES,
    RELEASE_GAP
  );

  localparam int TW = $clog2(TMAX + 1);
  localparam int LW = $clog2(LOSS_FILTER + 1);
  localparam int IW =
    (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [TW-1:0] T_RST =
    TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] T_TO =
    TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_ST =
    TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] T_GAP =
    TW'(RELEASE_GAP - 1);
  localparam logic [LW-1:0] T_LF =
    LW'(LOSS_FILTER - 1);
  localparam logic [IW-1:0] I_LAST =
    IW'(NUM_DOMAINS - 1);

  state_t state;
  state_t state_n;

  logic [TW-1:0] timer;
  logic [TW-1:0] timer_n;

  logic [LW-1:0] loss;
  logic [LW-1:0] loss_n;

  logic [IW-1:0] idx;
  logic [IW-1:0] idx_n;

  logic [NUM_DOMAINS-1:0] dom_n;
  logic [RETRY_W-1:0]     retry_n;
  logic                   lost_n;
  logic                   bump;
  logic                   lk;

  sync_2ff u_sync (
    .clk (refclk),
    .clr (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  assign pll_rst   = (state == S_PLLRST);
  assign ready     = (state == S_RUN);
  assign state_dbg = state;

  // state, shared timer, loss filter and sticky status
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= S_PLLRST;
      timer     <= '0;
      loss      <= '0;
      idx       <= '0;
      dom_reset <= '1;
      retry_cnt <= '0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      loss      <= loss_n;
      idx       <= idx_n;
      dom_reset <= dom_n;
      retry_cnt <= retry_n;
      lock_lost <= lost_n;
    end
  end

  // next-state: sequencing, timeouts, staggered release, loss
  always_comb begin
    state_n = state;
    timer_n = timer + TW'(1);
    loss_n  = '0;
    idx_n   = idx;
    dom_n   = dom_reset;
    retry_n = retry_cnt;
    lost_n  = lock_lost;
    bump    = 1'b0;

    unique case (state)
      S_PLLRST: begin
        dom_n = '1;
        if (timer == T_RST) begin
          state_n = S_WAITLOCK;
          timer_n = '0;
        end
      end

      S_WAITLOCK: begin
        dom_n = '1;
        if (lk) begin
          state_n = S_STABLE;
          timer_n = '0;
        end else if (timer == T_TO) begin
          state_n = S_PLLRST;
          timer_n = '0;
          bump    = 1'b1;
        end
      end

      S_STABLE: begin
        dom_n = '1;
        if (!lk) begin
          state_n = S_WAITLOCK;
          timer_n = '0;
        end else if (timer == T_ST) begin
          state_n = S_RELEASE;
          timer_n = '0;
          idx_n   = '0;
        end
      end

      S_RELEASE,
      S_RUN: begin
        if (!lk) begin
          loss_n = loss + LW'(1);
        end
        if (!lk && (loss == T_LF)) begin
          state_n = S_PLLRST;
          timer_n = '0;
          loss_n  = '0;
          idx_n   = '0;
          dom_n   = '1;
          lost_n  = 1'b1;
          bump    = 1'b1;
        end else if (state == S_RELEASE) begin
          if (timer == T_GAP) begin
            timer_n    = '0;
            dom_n[idx] = 1'b0;
            if (idx == I_LAST) begin
              state_n = S_RUN;
            end else begin
              idx_n = idx + IW'(1);
            end
          end
        end else begin
          timer_n = timer;
        end
      end

      default: begin
        state_n = S_PLLRST;
        timer_n = '0;
        dom_n   = '1;
      end
    endcase

    if (bump && (retry_cnt != '1)) begin
      retry_n = retry_cnt + RETRY_W'(1);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: vector table, corner sequences,
// and randomized lock traffic against a timeline reference model.
module tb_pll_reset_sequencer;

  localparam int RC  = 4;
  localparam int TO  = 32;
  localparam int ST  = 8;
  localparam int LF  = 3;
  localparam int GAP = 2;
  localparam int ND  = 4;
  localparam int RW  = 4;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          pll_rst;
  logic [ND-1:0] dom_reset;
  logic          ready;
  logic [RW-1:0] retry_cnt;
  logic          lock_lost;
  logic [2:0]    state_dbg;

  int n_vec = 0;
  int n_bad = 0;

  always #10 refclk = ~refclk;

  pll_reset_sequencer #(
    .RST_CYCLES    (RC),
    .LOCK_TIMEOUT  (TO),
    .STABLE_CYCLES (ST),
    .LOSS_FILTER   (LF),
    .NUM_DOMAINS   (ND),
    .RELEASE_GAP   (GAP),
    .RETRY_W       (RW)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .dom_reset  (dom_reset),
    .ready      (ready),
    .retry_cnt  (retry_cnt),
    .lock_lost  (lock_lost),
    .state_dbg  (state_dbg)
  );

  // model: phase number, edges spent in phase, zero run, status
  int m_ph;
  int m_el;
  int m_z;
  int m_retry;
  bit m_lost;
  bit m_q[$];

  function automatic logic [13:0] pk(
    input bit p, input logic [3:0] d, input bit rd,
    input int rt, input bit lo, input int st);
    return {p, d, rd, 4'(rt), lo, 3'(st)};
  endfunction

  function automatic logic [13:0] got();
    return {pll_rst, dom_reset, ready,
            retry_cnt, lock_lost, state_dbg};
  endfunction

  function automatic logic [13:0] m_exp();
    logic [3:0] d;
    logic [3:0] ones;
    ones = 4'hF;
    d = ones;
    if (m_ph == 3) d = 4'(ones << (m_el / GAP));
    if (m_ph == 4) d = 4'h0;
    return pk(m_ph == 0, d, m_ph == 4, m_retry, m_lost, m_ph);
  endfunction

  task automatic chk(input string nm,
                     input logic [13:0] g,
                     input logic [13:0] w);
    n_vec++;
    if (g !== w) begin
      n_bad++;
      $display("FAIL %s t=%0t got {rst,dom,rdy,retry,lost,st}=%h want %h",
               nm, $time, g, w);
    end
  endtask

  task automatic bump();
    if (m_retry < 15) m_retry++;
  endtask

  // one rising edge of the reference behaviour
  task automatic model_step(input bit r, input bit l);
    bit lk;
    int nph;
    if (r) begin
      m_ph = 0; m_el = 0; m_z = 0;
      m_retry = 0; m_lost = 0;
      m_q = {1'b0, 1'b0};
      return;
    end
    lk = m_q.pop_front();
    m_q.push_back(l);
    nph = m_ph;
    case (m_ph)
      0: if (m_el + 1 == RC) nph = 1;
      1: begin
        if (lk) nph = 2;
        else if (m_el + 1 == TO) begin bump(); nph = 0; end
      end
      2: begin
        if (!lk) nph = 1;
        else if (m_el + 1 == ST) nph = 3;
      end
      default: begin
        m_z = lk ? 0 : m_z + 1;
        if (m_z == LF) begin
          m_lost = 1; bump(); nph = 0;
        end else if (m_ph == 3 && m_el + 1 == GAP * ND) begin
          nph = 4;
        end
      end
    endcase
    if (nph != m_ph) m_el = 0;
    else m_el++;
    if (nph < 3) m_z = 0;
    m_ph = nph;
  endtask

  task automatic step(input bit r, input bit l);
    rst = r;
    pll_locked = l;
    @(posedge refclk);
    #1;
    model_step(r, l);
    chk("model", got(), m_exp());
  endtask

  typedef struct {
    bit          r;
    bit          l;
    int          hold;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit l, input int h,
                     input logic [13:0] e);
    vec_t v;
    v.r = r; v.l = l; v.hold = h; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    int seg;
    bit lv;
    bit r;

    // nominal bring-up, glitch, loss in RUN, rst in RUN
    add(1, 0, 1, pk(1, 4'hF, 0, 0, 0, 0));
    add(0, 0, 3, pk(1, 4'hF, 0, 0, 0, 0));
    add(0, 0, 1, pk(0, 4'hF, 0, 0, 0, 1));
    add(0, 1, 2, pk(0, 4'hF, 0, 0, 0, 1));
    add(0, 1, 1, pk(0, 4'hF, 0, 0, 0, 2));
    add(0, 1, 7, pk(0, 4'hF, 0, 0, 0, 2));
    add(0, 1, 1, pk(0, 4'hF, 0, 0, 0, 3));
    add(0, 1, 1, pk(0, 4'hF, 0, 0, 0, 3));
    add(0, 1, 1, pk(0, 4'hE, 0, 0, 0, 3));
    add(0, 1, 2, pk(0, 4'hC, 0, 0, 0, 3));
    add(0, 1, 2, pk(0, 4'h8, 0, 0, 0, 3));
    add(0, 1, 1, pk(0, 4'h8, 0, 0, 0, 3));
    add(0, 1, 1, pk(0, 4'h0, 1, 0, 0, 4));
    add(0, 1, 5, pk(0, 4'h0, 1, 0, 0, 4));
    add(0, 0, 2, pk(0, 4'h0, 1, 0, 0, 4));
    add(0, 1, 4, pk(0, 4'h0, 1, 0, 0, 4));
    add(0, 0, 3, pk(0, 4'h0, 1, 0, 0, 4));
    add(0, 1, 1, pk(0, 4'h0, 1, 0, 0, 4));
    add(0, 1, 1, pk(1, 4'hF, 0, 1, 1, 0));
    add(1, 1, 1, pk(1, 4'hF, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      repeat (tbl[i].hold) step(tbl[i].r, tbl[i].l);
      chk($sformatf("tbl%0d", i), got(), tbl[i].exp);
    end

    // lock never arrives: retry every RC+TO edges, saturating
    step(1, 0);
    for (int k = 1; k <= 17; k++) begin
      repeat (RC + TO - 1) step(0, 0);
      chk($sformatf("tmo_wait%0d", k), got(),
          pk(0, 4'hF, 0, (k - 1 > 15) ? 15 : k - 1, 0, 1));
      step(0, 0);
      chk($sformatf("tmo_retry%0d", k), got(),
          pk(1, 4'hF, 0, (k > 15) ? 15 : k, 0, 0));
    end

    // unstable lock: one low cycle restarts qualification
    step(1, 0);
    for (int i = 1; i <= 40; i++) begin
      step(0, i != 6);
      if (i == 8)
        chk("unst_back", got(), pk(0, 4'hF, 0, 0, 0, 1));
      if (i == 16)
        chk("unst_stab", got(), pk(0, 4'hF, 0, 0, 0, 2));
      if (i == 17)
        chk("unst_rel", got(), pk(0, 4'hF, 0, 0, 0, 3));
      if (i == 40)
        chk("unst_run", got(), pk(0, 4'h0, 1, 0, 0, 4));
    end

    // loss early in release aborts it in one edge
    step(1, 1);
    for (int i = 1; i <= 17; i++) begin
      step(0, !(i >= 13 && i <= 15));
      if (i == 16)
        chk("mid_rel", got(), pk(0, 4'hE, 0, 0, 0, 3));
      if (i == 17)
        chk("mid_loss", got(), pk(1, 4'hF, 0, 1, 1, 0));
    end

    // relock, then rst in the middle of release
    for (int i = 0; i < 80; i++) begin
      step(0, 1);
      if (m_ph == 3 && m_el >= 2) break;
    end
    chk("pre_rst_rel", got(), pk(0, 4'hE, 0, 1, 1, 3));
    step(1, 1);
    chk("rst_rel", got(), pk(1, 4'hF, 0, 0, 0, 0));

    // drop lock after 1100 for three cycles
    for (int i = 1; i <= 22; i++) begin
      step(0, !(i >= 18 && i <= 20));
      if (i == 17)
        chk("c_step", got(), pk(0, 4'hC, 0, 0, 0, 3));
      if (i == 21)
        chk("c_run", got(), pk(0, 4'h0, 1, 0, 0, 4));
      if (i == 22)
        chk("c_loss", got(), pk(1, 4'hF, 0, 1, 1, 0));
    end

    // random lock traffic with occasional resets
    lv = 1'b1;
    seg = 0;
    for (int rnd = 0; rnd < 6; rnd++) begin
      step(1, 0);
      for (int c = 0; c < 500; c++) begin
        if (seg == 0) begin
          lv = !lv;
          if (!lv) begin
            case ($urandom_range(0, 9))
              0, 1, 2: seg = $urandom_range(1, 2);
              3, 4, 5: seg = $urandom_range(3, 5);
              6, 7:    seg = 1;
              default: seg = $urandom_range(20, 45);
            endcase
          end else begin
            seg = $urandom_range(1, 50);
          end
        end
        r = ($urandom_range(0, 299) == 0);
        step(r, lv);
        seg--;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
